// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-lane writes and a 1-cycle registered read port.
// A clear sweep owns the array (busy_o=1) after reset or clr_i; port traffic is dropped meanwhile.
module ram_sdp_be #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 256,
   parameter int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int                RD_BYPASS = 1,
   parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clr_i,
   output logic                busy_o,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W/8-1:0] wr_be_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic                rd_en_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic [DATA_W-1:0]   rd_data_o,
   output logic                rd_valid_o
);

   localparam int                BE_W    = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                wr_in_rng, rd_in_rng, collide;
   logic [DATA_W-1:0]   rd_word, rd_merged;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [BE_W-1:0]     mem_be;
   logic [DATA_W-1:0]   mem_wdata;

   // Addresses past DEPTH only exist when DEPTH is not a power of two.
   assign wr_in_rng = ({1'b0, wr_addr_i} < DEPTH_C);
   assign rd_in_rng = ({1'b0, rd_addr_i} < DEPTH_C);
   assign collide   = wr_en_i && (wr_addr_i == rd_addr_i) && (RD_BYPASS != 0);
   assign rd_word   = mem_q[rd_addr_i];

   always_comb begin
      rd_merged = rd_word;
      for (int k = 0; k < BE_W; k++) begin
         if (wr_be_i[k]) begin
            rd_merged[8*k +: 8] = wr_data_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = wr_addr_i;
      mem_be     = wr_be_i;
      mem_wdata  = wr_data_i;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_be    = '1;
            mem_wdata = CLR_VAL;
            ptr_d     = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_C) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         ST_IDLE: begin
            mem_we = wr_en_i && wr_in_rng;
            if (rd_en_i) begin
               rd_valid_d = 1'b1;
               rd_data_d  = !rd_in_rng ? '0 : (collide ? rd_merged : rd_word);
            end
            if (clr_i) begin
               state_d = ST_CLEAR;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (mem_be[k]) begin
               mem_q[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy_o     = (state_q == ST_CLEAR);
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: three instances (write-first, read-first, non-power-of-two depth)
// share one stimulus stream and are checked against a word-array model every cycle.
module tb_ram_sdp_be;

   localparam int N = 3;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        clr     = 1'b0;
   logic        wr_en   = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [3:0]  wr_be   = '0;
   logic [31:0] wr_data = '0;
   logic        rd_en   = 1'b0;
   logic [7:0]  rd_addr = '0;

   logic        busy_w [N];
   logic        vld_w  [N];
   logic [31:0] dat_w  [N];

   always #5 clk = ~clk;

   ram_sdp_be #(.DATA_W(32), .DEPTH(256), .RD_BYPASS(1)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy_w[0]),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(dat_w[0]), .rd_valid_o(vld_w[0]));

   ram_sdp_be #(.DATA_W(32), .DEPTH(256), .RD_BYPASS(0)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy_w[1]),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(dat_w[1]), .rd_valid_o(vld_w[1]));

   ram_sdp_be #(.DATA_W(32), .DEPTH(200), .RD_BYPASS(1)) u2 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy_w[2]),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(dat_w[2]), .rd_valid_o(vld_w[2]));

   function automatic int dep(input int i);
      return (i == 2) ? 200 : 256;
   endfunction

   function automatic bit byp(input int i);
      return (i != 1);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) r[8*k +: 8] = n[8*k +: 8];
      end
      return r;
   endfunction

   // Model: clear is treated as an instant wipe plus a busy countdown.
   logic [31:0] m [N][256];
   int          busy_left [N];
   logic [31:0] exp_dat [N];
   logic        exp_vld [N];

   always begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            busy_left[i] = dep(i);
            exp_dat[i]   = '0;
            exp_vld[i]   = 1'b0;
            for (int j = 0; j < 256; j++) m[i][j] = '0;
         end else if (busy_left[i] > 0) begin
            busy_left[i] = busy_left[i] - 1;
            exp_vld[i]   = 1'b0;
         end else begin
            exp_vld[i] = rd_en;
            if (rd_en) begin
               if (int'(rd_addr) >= dep(i))
                  exp_dat[i] = '0;
               else if (byp(i) && wr_en && wr_addr == rd_addr)
                  exp_dat[i] = merge(m[i][rd_addr], wr_data, wr_be);
               else
                  exp_dat[i] = m[i][rd_addr];
            end
            if (wr_en && int'(wr_addr) < dep(i))
               m[i][wr_addr] = merge(m[i][wr_addr], wr_data, wr_be);
            if (clr) begin
               busy_left[i] = dep(i);
               for (int j = 0; j < 256; j++) m[i][j] = '0;
            end
         end
      end
   end

   int          checks   = 0;
   int          failures = 0;
   int          runlen [N];
   logic        pin_vld = 1'b0;
   logic [31:0] pin_dat [N];

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, i, $time, act, exp);
      end
   endtask

   always begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("busy", i, 32'(busy_w[i]), 32'(busy_left[i] > 0));
         chk("rd_valid", i, 32'(vld_w[i]), 32'(exp_vld[i]));
         chk("rd_data", i, dat_w[i], exp_dat[i]);
         if (!rst_n) begin
            chk("rst_busy", i, 32'(busy_w[i]), 32'd1);
            chk("rst_valid", i, 32'(vld_w[i]), 32'd0);
            chk("rst_data", i, dat_w[i], 32'd0);
            runlen[i] = 0;
         end else if (busy_w[i]) begin
            runlen[i] = runlen[i] + 1;
         end else if (runlen[i] > 0) begin
            chk("busy_len", i, 32'(runlen[i]), 32'(dep(i)));
            runlen[i] = 0;
         end
         if (pin_vld && rst_n) begin
            chk("pin_data", i, dat_w[i], pin_dat[i]);
            chk("pin_valid", i, 32'(vld_w[i]), 32'd1);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic pin(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      pin_dat = '{e0, e1, e2};
      pin_vld = 1'b1;
      step(1);
      pin_vld = 1'b0;
   endtask

   task automatic rd_pin(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2);
      rd_en = 1'b1; rd_addr = a;
      step(1);
      rd_en = 1'b0;
      pin(e0, e1, e2);
   endtask

   task automatic wrrd_pin(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      rd_en = 1'b1; rd_addr = a;
      step(1);
      wr_en = 1'b0; rd_en = 1'b0;
      pin(e0, e1, e2);
   endtask

   initial begin
      for (int i = 0; i < N; i++) runlen[i] = 0;
      step(3);
      rst_n = 1'b1;
      step(260);

      rd_pin(8'd0, 32'h0, 32'h0, 32'h0);
      rd_pin(8'd255, 32'h0, 32'h0, 32'h0);

      wr(8'd5, 32'hDEADBEEF, 4'hF);
      rd_pin(8'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      wr(8'd5, 32'h11223344, 4'b0101);
      rd_pin(8'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

      wrrd_pin(8'd9, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D);
      rd_pin(8'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
      wrrd_pin(8'd9, 32'hAABBCCDD, 4'b0011, 32'hCAFECCDD, 32'hCAFEF00D, 32'hCAFECCDD);
      wr(8'd9, 32'hFFFFFFFF, 4'h0);
      rd_pin(8'd9, 32'hCAFECCDD, 32'hCAFECCDD, 32'hCAFECCDD);

      // back-to-back reads
      rd_en = 1'b1; rd_addr = 8'd5;
      step(1);
      rd_addr = 8'd9;
      pin_dat = '{32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
      pin_vld = 1'b1;
      step(1);
      rd_en = 1'b0;
      pin_dat = '{32'hCAFECCDD, 32'hCAFECCDD, 32'hCAFECCDD};
      step(1);
      pin_vld = 1'b0;

      wr(8'd250, 32'h12345678, 4'hF);
      rd_pin(8'd250, 32'h12345678, 32'h12345678, 32'h0);
      wr(8'd199, 32'h0BADF00D, 4'hF);
      rd_pin(8'd199, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D);

      for (int a = 0; a < 4; a++) wr(8'(a), 32'h1000 + 32'(a), 4'hF);
      rd_pin(8'd3, 32'h1003, 32'h1003, 32'h1003);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      for (int c = 0; c < 190; c++) begin
         wr_en = 1'b1; wr_addr = 8'(c % 4); wr_data = $urandom; wr_be = 4'hF;
         rd_en = 1'b1; rd_addr = 8'(c % 4);
         clr = (c == 50);
         step(1);
      end
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
      step(80);
      for (int a = 0; a < 4; a++) rd_pin(8'(a), 32'h0, 32'h0, 32'h0);

      wr(8'd7, 32'h5A5A5A5A, 4'hF);
      rd_pin(8'd7, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(100);
      #1;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(260);
      rd_pin(8'd7, 32'h0, 32'h0, 32'h0);
      rd_pin(8'd250, 32'h0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
